// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO between a host writer and a UART transmitter.
// Head byte is presented combinationally; occupancy flags derive from the registered count.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_r;
    logic                  wr_en;
    logic                  rd_en;

    assign empty       = (count_r == '0);
    assign full        = (count_r == CNT_W'(DEPTH));
    assign almost_full = (count_r >= CNT_W'(AF_THRESH));
    assign count       = count_r;

    // s_ready masks on rst so no write can slip in during reset.
    assign s_ready = !full && !rst;
    assign m_valid = !empty;
    assign m_data  = mem[rd_ptr];

    assign wr_en = s_valid && s_ready;
    assign rd_en = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !rd_en)
                count_r <= count_r + CNT_W'(1);
            else if (rd_en && !wr_en)
                count_r <= count_r - CNT_W'(1);
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected bytes, a monitor
// pops and compares them whenever the DUT hands a byte to the transmitter.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int c, input int e, input int f, input int af);
        chk({tag, " count"}, count, c);
        chk({tag, " empty"}, empty, e);
        chk({tag, " full"}, full, f);
        chk({tag, " almost_full"}, almost_full, af);
        chk({tag, " m_valid"}, m_valid, (c != 0));
    endtask

    task automatic write_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            exp_q.push_back(8'(base + i));
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        repeat (n) tick();
        m_ready = 1'b0;
    endtask

    // Monitor: a read is accepted at the coming edge when m_valid && m_ready;
    // reads under flush or reset are discarded by the DUT and not checked.
    always @(negedge clk) begin
        if (!rst && !flush && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no output", m_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    n_err++;
                    $display("FAIL read_order: got 0x%0h, expected 0x%0h (t=%0t)", m_data, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
        tick();
        s_valid = 1'b1;
        tick();
        chk("reset s_ready", s_ready, 0);
        chk_flags("reset", 0, 1, 0, 0);
        s_valid = 1'b0;
        rst = 1'b0;

        // Single byte latency
        s_valid = 1'b1; s_data = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        s_valid = 1'b0;
        chk_flags("single", 1, 0, 0, 0);
        chk("single m_data", m_data, 8'hA5);
        drain(1);
        chk_flags("single drained", 0, 1, 0, 0);

        // Fill to full, watching almost_full and full
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 8'(i); exp_q.push_back(8'(i));
            tick();
            chk_flags("fill", i + 1, 0, (i + 1 == 16), (i + 1 >= 12));
        end
        chk("full s_ready", s_ready, 0);
        s_data = 8'h10;
        tick();
        chk("17th rejected count", count, 16);

        // Full boundary: read only, write refused
        s_data = 8'h55; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("full rd no wr count", count, 15);
        chk("after read s_ready", s_ready, 1);
        exp_q.push_back(8'h55);
        tick();
        s_valid = 1'b0;
        chk("refill count", count, 16);
        drain(16);
        chk_flags("full drained", 0, 1, 0, 0);

        // Steady state at count 5 through pointer wrap
        write_bytes(5, 8'h20);
        chk("steady pre count", count, 5);
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h25 + i); exp_q.push_back(8'(8'h25 + i));
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        chk("steady count", count, 5);
        drain(5);
        chk_flags("steady drained", 0, 1, 0, 0);

        // Flush at count 7 with concurrent write and read
        write_bytes(7, 8'h60);
        chk("preflush count", count, 7);
        flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk_flags("flush", 0, 1, 0, 0);
        write_bytes(1, 8'h77);
        chk("post flush m_data", m_data, 8'h77);
        drain(1);
        chk_flags("post flush drained", 0, 1, 0, 0);

        // Reset mid-stream at count 9
        write_bytes(9, 8'h80);
        chk("prereset count", count, 9);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h99;
        #1;
        chk("rst s_ready", s_ready, 0);
        exp_q.delete();
        tick();
        rst = 1'b0; s_valid = 1'b0;
        chk_flags("midreset", 0, 1, 0, 0);
        write_bytes(1, 8'h3C);
        chk("post reset m_data", m_data, 8'h3C);
        drain(1);
        chk_flags("post reset drained", 0, 1, 0, 0);

        chk("scoreboard leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width carried to the UART transmitter.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AF_THRESH, default 12, almost_full threshold in entries; SHALL be between 1 and DEPTH.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  synchronous discard of all stored entries.
REQ-007 s_data  input  DATA_WIDTH  write byte from the host side.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  FIFO can accept a byte this cycle.
REQ-010 m_data  output  DATA_WIDTH  head-of-queue byte toward the UART transmitter.
REQ-011 m_valid  output  1  m_data holds a valid byte.
REQ-012 m_ready  input  1  UART transmitter consumes the head byte this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 empty / full / almost_full  output  1 each  occupancy flags.

Function
REQ-015 Write accept SHALL occur exactly when s_valid and s_ready are both high at a rising edge; byte stored at write pointer, write pointer advances.
REQ-016 Read accept SHALL occur exactly when m_valid and m_ready are both high at a rising edge; read pointer advances.
REQ-017 s_ready SHALL equal (not full) and (not rst); m_valid SHALL equal (not empty).
REQ-018 Show-ahead: m_data SHALL present the entry at the read pointer combinationally, valid whenever m_valid is high; value when m_valid is low is don't-care.
REQ-019 Latency: a byte written at edge N into an empty FIFO SHALL appear on m_data with m_valid high in the cycle after edge N; no same-cycle bypass.
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 count SHALL increment on write-only, decrement on read-only, and stay unchanged on simultaneous read and write.
REQ-022 empty SHALL be high iff count == 0; full high iff count == DEPTH; almost_full high iff count >= AF_THRESH; all derived from registered count.
REQ-023 Full boundary: s_ready is low, so no write is accepted even when a read occurs in the same cycle; count goes DEPTH to DEPTH-1.
REQ-024 Empty boundary: no read is possible; a write in that cycle is accepted and count goes 0 to 1.
REQ-025 Bytes SHALL emerge in strict write order with no loss, duplication or corruption.
REQ-026 flush SHALL, at the next edge, zero both pointers and count; any concurrent write or read is discarded; s_ready stays as computed from pre-flush full.
REQ-027 Storage array SHALL NOT be reset or cleared; only pointers and count are.

Reset
REQ-028 rst high at an edge SHALL set pointers and count to 0: empty=1, full=0, almost_full=0, m_valid=0.
REQ-029 While rst is high s_ready SHALL be 0 and no write or read SHALL be accepted.
REQ-030 rst SHALL take priority over flush, writes and reads, including mid-stream with the FIFO partially filled.
REQ-031 First write SHALL be accepted at the first edge after rst deasserts.

Verification
REQ-032 Reset, then write 0xA5 with m_ready=0 -> next cycle m_valid=1, m_data=0xA5, count=1, empty=0.
REQ-033 Write 16 bytes 0x00..0x0F, m_ready=0 -> almost_full high from count 12; full=1 and s_ready=0 at count 16; 17th byte not accepted; drain returns 0x00..0x0F in order.
REQ-034 Full FIFO with s_valid=1 and m_ready=1 for one cycle -> one read, no write, count=15; next cycle write accepted, count=16.
REQ-035 Count 5 with s_valid=1 and m_ready=1 held 40 cycles (pointer wrap) -> count stays 5; output sequence equals input sequence delayed by 5 entries.
REQ-036 Count 7, then flush with s_valid=1 and m_ready=1 in same cycle -> next cycle count=0, empty=1, m_valid=0, flushed byte never emerges.
REQ-037 Count 9, rst high one cycle with s_valid=1 -> s_ready=0 during reset; afterwards count=0, empty=1; next write 0x3C is the first byte read.
